// File: rtl/stopwatch_cu.sv
// stopwatch_cu: debounces run/clear buttons and sequences the stopwatch datapath controls
module stopwatch_cu #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SAMPLE_HZ = 1_000,
    parameter int DB_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clear,
    output logic       run,
    output logic       clear,
    output logic [1:0] state
);
    localparam int TICK_DIV = CLK_FREQ / SAMPLE_HZ;
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [1:0][DB_DEPTH-1:0]     sr_q, sr_d;
    logic [1:0]                   lvl_q, lvl_d;
    logic [1:0]                   dly_q, dly_d;
    logic [1:0]                   btn, pulse;
    logic                         tick;
    state_t                       state_q, state_d;

    assign btn = {btn_clear, btn_run};

    // Sample tick, per-button shift/debounce and one-cycle-delayed level for edge detect
    always_comb begin
        tick  = cnt_q == CW'(TICK_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        dly_d = lvl_q;
        pulse = lvl_q & ~dly_q;
        sr_d  = sr_q;
        lvl_d = lvl_q;
        for (int i = 0; i < 2; i++) begin
            sr_d[i]  = tick ? {sr_q[i][DB_DEPTH-2:0], btn[i]} : sr_q[i];
            lvl_d[i] = (&sr_q[i]) ? 1'b1 : (~|sr_q[i]) ? 1'b0 : lvl_q[i];
        end
    end

    // All state registers, cleared together by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            lvl_q   <= '0;
            dly_q   <= '0;
            state_q <= ST_STOP;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            lvl_q   <= lvl_d;
            dly_q   <= dly_d;
            state_q <= state_d;
        end
    end

    // Next state: run press wins over clear in STOP; clear is ignored while running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:  state_d = pulse[0] ? ST_RUN : pulse[1] ? ST_CLEAR : ST_STOP;
            ST_RUN:   state_d = pulse[0] ? ST_STOP : ST_RUN;
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        run   = state_q == ST_RUN;
        clear = state_q == ST_CLEAR;
        state = state_q;
    end
endmodule

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
Control unit feeding the stopwatch datapath. It takes two raw push-button inputs (run/stop and clear) and debounces each by periodic sampling. It detects press edges and runs a Moore FSM that produces the datapath's run and clear controls. The run and clear outputs connect directly to the same-named inputs of the stopwatch datapath.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
SAMPLE_HZ, 1_000, debounce sampling rate in Hz; TICK_DIV = CLK_FREQ/SAMPLE_HZ, must be >= 2
DB_DEPTH, 8, consecutive equal samples required to change a debounced level, range 2..16

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
btn_run  input  1  raw run/stop button, active-high, bouncy, pre-synchronised to clk
btn_clear  input  1  raw clear button, active-high, bouncy, pre-synchronised to clk
run  output  1  datapath count enable, level
clear  output  1  datapath clear, single-cycle pulse
state  output  2  FSM state for debug LEDs: 00 STOP, 01 RUN, 10 CLEAR

Behaviour:
- Reset (reset==0 at a clk edge) clears the following on that edge: tick counter, both sample shift registers, both debounced levels, both edge-detect registers, and FSM (to STOP). Outputs after reset: run=0, clear=0, state=00. Reset mid-RUN forces run=0 from the next edge.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when count==TICK_DIV-1.
  - The first tick after reset occurs on the TICK_DIV-th rising edge after release.
- Debounce (per button):
  - On each tick, shift the raw input into a DB_DEPTH-bit register.
  - Debounced level goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - The level updates on the clk edge after the tick that completes the pattern.
  - Level is 0 out of reset; a button held through reset registers as a press after DB_DEPTH ticks.
- Edge detect: press pulse = debounced level AND NOT its one-cycle-delayed copy. Exactly one clk cycle wide; release produces no pulse.
- FSM, Moore; outputs decoded from the state register only:
  - STOP: run_pulse -> RUN. Else clear_pulse -> CLEAR. Both in the same cycle -> RUN (run wins; clear is dropped, not queued).
  - RUN: run_pulse -> STOP. clear_pulse is ignored (no clear while running).
  - CLEAR: unconditional -> STOP after one cycle.
  - run=1 only in RUN. clear=1 only in CLEAR, so it is exactly one clk wide.
- Latency: a press pulse in cycle N gives the new state/outputs visible in cycle N+1.
- Glitch rule: any bounce shorter than DB_DEPTH consecutive equal samples produces no state change.

Test Plan (CLK_FREQ=1000, SAMPLE_HZ=100 -> TICK_DIV=10; DB_DEPTH=4):
1. Reset: hold reset=0 for 3 cycles with both buttons 0, release -> run=0, clear=0, state=00. First tick lands on the 10th edge after release.
2. Clean run press: btn_run=1 held for 60 cycles -> debounced high after 4th tick; run_pulse for 1 cycle; run=1, state=01 on the following edge. Release -> run stays 1. Second identical press -> run=0, state=00.
3. Bounce rejection: btn_run toggles so no 4 consecutive tick samples are equal, for 100 cycles -> run stays 0, state stays 00.
4. Clear from STOP: btn_clear pressed clean -> clear=1 for exactly one cycle, state 10 then 00, run=0 throughout. Clear pressed while state=01 -> no clear pulse, run stays 1.
5. Simultaneous: both buttons asserted on the same cycle, identical waveforms, from STOP -> state=01, run=1, no clear pulse ever asserted.
6. Reset mid-run: in RUN, drive reset=0 for 1 cycle -> run=0, state=00 on that edge. With btn_run still held, run re-asserts only after 4 more ticks plus 2 cycles.
